rv32im_decode_stage: RTL and testbench
======================================

Name: rv32im_decode_stage

Overview:
Registered, parametrised successor to the combinational RV32IM control decoder. Decodes the IF/ID instruction word into the existing control bundle (ALUOP, IMMflag, WRITEENABLE, SELECTWRITE, READ, WRITE, LOADSIGNAL, STORESIGNAL, BRANCHSIGNAL) and latches it into the ID/EX pipeline register. Adds stall/flush handling, multi-cycle MUL/DIV hold via a down-counter, illegal-instruction detection, JAL/JALR distinction and x0 write suppression. Sits between the IF/ID register and the EX stage (alu.v, dmem.v).

Parameters:
ENABLE_M, 1, when 0 every M-extension encoding decodes as illegal
MUL_CYCLES, 2, EX occupancy in cycles for MUL/MULH/MULHSU/MULHU (>=1)
DIV_CYCLES, 8, EX occupancy in cycles for DIV/DIVU/REM/REMU (>=1)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
INSTRUCTION  in  32  instruction word from IF/ID
IF_VALID  in  1  INSTRUCTION is a real instruction (0 = bubble)
BUSYWAIT  in  1  data memory busy; freezes the stage
FLUSH  in  1  branch/jump taken in EX; squash the instruction being decoded
STALL  out  1  to PC/IF: hold IF/ID this cycle
EX_VALID  out  1  EX register holds a real instruction
EX_RD  out  5  destination register
ALUOP  out  5  ALU operation (existing encoding)
IMMflag, SELECTWRITE, READ, WRITE, WRITEENABLE  out  1 each  as in the existing control unit
LOADSIGNAL  out  3  1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LUI/AUIPC
STORESIGNAL  out  2  1 SB, 2 SH, 3 SW
BRANCHSIGNAL  out  3  1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
JUMPSIGNAL  out  2  1 JAL, 2 JALR
ILLEGAL  out  1  one-cycle flag with the bubble produced by an undecodable word

Behaviour:
- Reset (async): all outputs 0, counter 0, state ISSUE.
- Latency: decode happens in the cycle the word is presented. Its control appears on outputs after the next rising edge.
- ALUOP encoding is unchanged: 00000 pass, 00001 ADD, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SUB, 01001 MUL, 01010 MULH, 01011 MULHU, 01100 MULHSU, 01101 DIV, 01110 DIVU, 01111 REM, 10000 REMU, 10001 SLT, 10010 SLTU.
- Per-opcode decode matches the existing control unit, with these changes:
  - Loads and stores use ALUOP 00001 (address add).
  - JAL/JALR set JUMPSIGNAL and WRITEENABLE=1.
  - WRITEENABLE is forced 0 when rd=0.
- Edge priority: RESET > BUSYWAIT > FLUSH > MULTI hold > normal load.
  - BUSYWAIT=1: EX register, counter and state all hold. STALL=1. READ/WRITE stay asserted until the edge after BUSYWAIT falls.
  - FLUSH=1 (BUSYWAIT=0): EX register loads a bubble (all controls 0, EX_VALID=0). Counter cleared, state returns to ISSUE.
  - IF_VALID=0: a bubble is loaded.
  - Illegal word with IF_VALID=1: bubble with ILLEGAL=1. Illegal means unknown opcode, unlisted func3/func7 combination, or M op with ENABLE_M=0.
- FSM:
  - ISSUE: on loading a MUL-class op with MUL_CYCLES>1, counter := MUL_CYCLES-1 and go to MULTI. DIV-class ops do the same with DIV_CYCLES.
  - MULTI: EX register holds the same op and STALL=1. Counter decrements on each edge with BUSYWAIT=0. When counter reaches 1→0, STALL drops combinationally the following cycle and state returns to ISSUE. The next instruction loads on that edge.
- STALL = BUSYWAIT | (state==MULTI).
- Latency 1 (MUL_CYCLES=1 or DIV_CYCLES=1) never enters MULTI.
- Counter width is $clog2(max(MUL_CYCLES, DIV_CYCLES)+1).
- Reset mid-MULTI returns to ISSUE with a bubble.

Decomposition:
- Package rv32im_ctrl_pkg holds:
  - opcode constants
  - ALUOP, LOADSIGNAL, STORESIGNAL, BRANCHSIGNAL, JUMPSIGNAL constants
  - packed ctrl_bundle_t struct
- Sub-module rv32im_ctrl_decode is purely combinational: INSTRUCTION → ctrl_bundle_t, ILLEGAL, is_mul, is_div.
- The top holds the EX register, the FSM and the counter.

Test Plan:
- ADDI x1,x0,5 (0x00500093), IF_VALID=1 → next edge: ALUOP=00001, IMMflag=1, WRITEENABLE=1, EX_RD=1, EX_VALID=1, STALL=0.
- ADD x0,x1,x2 (0x00208033) → ALUOP=00001, WRITEENABLE=0 (rd=0), EX_VALID=1.
- DIV x3,x1,x2 (0x0220C1B3), DIV_CYCLES=8 → ALUOP=01101 held and STALL=1 for 7 cycles. Next word loads on the 8th edge. Repeat with ENABLE_M=0 → ILLEGAL=1, EX_VALID=0.
- LW x5,0(x1) (0x0000A283) followed by BUSYWAIT=1 for 3 cycles → READ=1, LOADSIGNAL=3, SELECTWRITE=1 held throughout with STALL=1. Following SW (0x0050A023) appears the edge after BUSYWAIT falls, with WRITE=1, READ=0, STORESIGNAL=3.
- FLUSH=1 during MULTI (counter=4) → next edge EX_VALID=0, all controls 0, STALL=0. FLUSH=1 together with BUSYWAIT=1 → registers hold.
- 0xFFFFFFFF → ILLEGAL=1 for exactly one cycle, all enables 0. RESET asserted mid-MULTI, asynchronously → all outputs 0 immediately.

Source files
------------

// File: rtl/rv32im_ctrl_pkg.sv
// Shared encodings and the control bundle carried from decode into the ID/EX register.
package rv32im_ctrl_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // func7 groups
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation codes
    localparam logic [4:0] ALU_PASS   = 5'b00000;
    localparam logic [4:0] ALU_ADD    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_SUB    = 5'b01000;
    localparam logic [4:0] ALU_MUL    = 5'b01001;
    localparam logic [4:0] ALU_MULH   = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_MULHSU = 5'b01100;
    localparam logic [4:0] ALU_DIV    = 5'b01101;
    localparam logic [4:0] ALU_DIVU   = 5'b01110;
    localparam logic [4:0] ALU_REM    = 5'b01111;
    localparam logic [4:0] ALU_REMU   = 5'b10000;
    localparam logic [4:0] ALU_SLT    = 5'b10001;
    localparam logic [4:0] ALU_SLTU   = 5'b10010;

    // Load selects (LUI/AUIPC reuse the load path to write the immediate result)
    localparam logic [2:0] LD_NONE  = 3'd0;
    localparam logic [2:0] LD_LB    = 3'd1;
    localparam logic [2:0] LD_LH    = 3'd2;
    localparam logic [2:0] LD_LW    = 3'd3;
    localparam logic [2:0] LD_LBU   = 3'd4;
    localparam logic [2:0] LD_LHU   = 3'd5;
    localparam logic [2:0] LD_UPPER = 3'd6;

    // Store selects
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    // Branch selects
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    // Jump selects
    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_JAL  = 2'd1;
    localparam logic [1:0] JMP_JALR = 2'd2;

    typedef struct packed {
        logic [4:0] aluop;
        logic       immflag;
        logic       selectwrite;
        logic       read;
        logic       write;
        logic       writeenable;
        logic [2:0] loadsignal;
        logic [1:0] storesignal;
        logic [2:0] branchsignal;
        logic [1:0] jumpsignal;
        logic [4:0] rd;
    } ctrl_bundle_t;

    typedef enum logic [0:0] {
        S_ISSUE = 1'b0,
        S_MULTI = 1'b1
    } stage_state_t;

endpackage

// File: rtl/rv32im_ctrl_decode.sv
// Combinational instruction decoder: instruction word to control bundle plus class flags.
module rv32im_ctrl_decode
    import rv32im_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]  i_instr,
    output ctrl_bundle_t o_ctrl,
    output logic         o_illegal,
    output logic         o_is_mul,
    output logic         o_is_div
);

    logic [6:0]   w_opcode;
    logic [4:0]   w_rd;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    logic [9:0]   w_unused_src;
    ctrl_bundle_t w_ctrl;
    logic         w_illegal;
    logic         w_is_mul;
    logic         w_is_div;
    logic         w_has_rd;

    assign w_opcode     = i_instr[6:0];
    assign w_rd         = i_instr[11:7];
    assign w_funct3     = i_instr[14:12];
    assign w_funct7     = i_instr[31:25];
    // Register sources and shift amounts are not needed to form control
    assign w_unused_src = i_instr[24:15];

    // Opcode / func3 / func7 decode, then rd and x0 write suppression
    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        w_has_rd  = 1'b0;
        case (w_opcode)
            OP_REG: begin
                w_has_rd           = 1'b1;
                w_ctrl.writeenable = 1'b1;
                case (w_funct7)
                    F7_BASE: begin
                        case (w_funct3)
                            3'b000:  w_ctrl.aluop = ALU_ADD;
                            3'b001:  w_ctrl.aluop = ALU_SLL;
                            3'b010:  w_ctrl.aluop = ALU_SLT;
                            3'b011:  w_ctrl.aluop = ALU_SLTU;
                            3'b100:  w_ctrl.aluop = ALU_XOR;
                            3'b101:  w_ctrl.aluop = ALU_SRL;
                            3'b110:  w_ctrl.aluop = ALU_OR;
                            default: w_ctrl.aluop = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (w_funct3)
                            3'b000:  w_ctrl.aluop = ALU_SUB;
                            3'b101:  w_ctrl.aluop = ALU_SRA;
                            default: w_illegal    = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        if (!ENABLE_M) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_is_mul = ~w_funct3[2];
                            w_is_div = w_funct3[2];
                            case (w_funct3)
                                3'b000:  w_ctrl.aluop = ALU_MUL;
                                3'b001:  w_ctrl.aluop = ALU_MULH;
                                3'b010:  w_ctrl.aluop = ALU_MULHSU;
                                3'b011:  w_ctrl.aluop = ALU_MULHU;
                                3'b100:  w_ctrl.aluop = ALU_DIV;
                                3'b101:  w_ctrl.aluop = ALU_DIVU;
                                3'b110:  w_ctrl.aluop = ALU_REM;
                                default: w_ctrl.aluop = ALU_REMU;
                            endcase
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                w_has_rd           = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ctrl.immflag     = 1'b1;
                case (w_funct3)
                    3'b000: w_ctrl.aluop = ALU_ADD;
                    3'b010: w_ctrl.aluop = ALU_SLT;
                    3'b011: w_ctrl.aluop = ALU_SLTU;
                    3'b100: w_ctrl.aluop = ALU_XOR;
                    3'b110: w_ctrl.aluop = ALU_OR;
                    3'b111: w_ctrl.aluop = ALU_AND;
                    3'b001: begin
                        if (w_funct7 == F7_BASE) w_ctrl.aluop = ALU_SLL;
                        else                     w_illegal    = 1'b1;
                    end
                    default: begin
                        if (w_funct7 == F7_BASE)     w_ctrl.aluop = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_ctrl.aluop = ALU_SRA;
                        else                         w_illegal    = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                w_has_rd           = 1'b1;
                w_ctrl.aluop       = ALU_ADD;
                w_ctrl.immflag     = 1'b1;
                w_ctrl.read        = 1'b1;
                w_ctrl.selectwrite = 1'b1;
                w_ctrl.writeenable = 1'b1;
                case (w_funct3)
                    3'b000:  w_ctrl.loadsignal = LD_LB;
                    3'b001:  w_ctrl.loadsignal = LD_LH;
                    3'b010:  w_ctrl.loadsignal = LD_LW;
                    3'b100:  w_ctrl.loadsignal = LD_LBU;
                    3'b101:  w_ctrl.loadsignal = LD_LHU;
                    default: w_illegal         = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_ctrl.aluop   = ALU_ADD;
                w_ctrl.immflag = 1'b1;
                w_ctrl.write   = 1'b1;
                case (w_funct3)
                    3'b000:  w_ctrl.storesignal = ST_SB;
                    3'b001:  w_ctrl.storesignal = ST_SH;
                    3'b010:  w_ctrl.storesignal = ST_SW;
                    default: w_illegal          = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                w_ctrl.aluop = ALU_SUB;
                case (w_funct3)
                    3'b000:  w_ctrl.branchsignal = BR_BEQ;
                    3'b001:  w_ctrl.branchsignal = BR_BNE;
                    3'b100:  w_ctrl.branchsignal = BR_BLT;
                    3'b101:  w_ctrl.branchsignal = BR_BGE;
                    3'b110:  w_ctrl.branchsignal = BR_BLTU;
                    3'b111:  w_ctrl.branchsignal = BR_BGEU;
                    default: w_illegal           = 1'b1;
                endcase
            end
            OP_LUI: begin
                w_has_rd           = 1'b1;
                w_ctrl.aluop       = ALU_PASS;
                w_ctrl.immflag     = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ctrl.loadsignal  = LD_UPPER;
            end
            OP_AUIPC: begin
                w_has_rd           = 1'b1;
                w_ctrl.aluop       = ALU_ADD;
                w_ctrl.immflag     = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ctrl.loadsignal  = LD_UPPER;
            end
            OP_JAL: begin
                w_has_rd           = 1'b1;
                w_ctrl.aluop       = ALU_ADD;
                w_ctrl.immflag     = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ctrl.jumpsignal  = JMP_JAL;
            end
            OP_JALR: begin
                w_has_rd           = 1'b1;
                w_ctrl.aluop       = ALU_ADD;
                w_ctrl.immflag     = 1'b1;
                w_ctrl.writeenable = 1'b1;
                w_ctrl.jumpsignal  = JMP_JALR;
                if (w_funct3 != 3'b000) w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_illegal) begin
            w_ctrl   = '0;
            w_is_mul = 1'b0;
            w_is_div = 1'b0;
        end else begin
            w_ctrl.rd = w_has_rd ? w_rd : 5'd0;
            if (w_rd == 5'd0) w_ctrl.writeenable = 1'b0;
        end
    end

    assign o_ctrl    = w_ctrl;
    assign o_illegal = w_illegal;
    assign o_is_mul  = w_is_mul;
    assign o_is_div  = w_is_div;

endmodule

// File: rtl/rv32im_decode_stage.sv
// Registered decode stage: ID/EX control register, multi-cycle MUL/DIV hold FSM and stall.
module rv32im_decode_stage
    import rv32im_ctrl_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        IF_VALID,
    input  logic        BUSYWAIT,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        EX_VALID,
    output logic [4:0]  EX_RD,
    output logic [4:0]  ALUOP,
    output logic        IMMflag,
    output logic        SELECTWRITE,
    output logic        READ,
    output logic        WRITE,
    output logic        WRITEENABLE,
    output logic [2:0]  LOADSIGNAL,
    output logic [1:0]  STORESIGNAL,
    output logic [2:0]  BRANCHSIGNAL,
    output logic [1:0]  JUMPSIGNAL,
    output logic        ILLEGAL
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam bit          MUL_MULTI  = (MUL_CYCLES > 1);
    localparam bit          DIV_MULTI  = (DIV_CYCLES > 1);

    ctrl_bundle_t     w_dec_ctrl;
    logic             w_dec_illegal;
    logic             w_dec_is_mul;
    logic             w_dec_is_div;

    stage_state_t     r_state;
    stage_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    ctrl_bundle_t     r_ex;
    ctrl_bundle_t     w_ex_nxt;
    logic             r_ex_valid;
    logic             w_ex_valid_nxt;
    logic             r_illegal;
    logic             w_illegal_nxt;

    rv32im_ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .i_instr   (INSTRUCTION),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_is_mul  (w_dec_is_mul),
        .o_is_div  (w_dec_is_div)
    );

    // Next-state, counter and ID/EX contents; busy memory freezes everything
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ex_nxt       = r_ex;
        w_ex_valid_nxt = r_ex_valid;
        w_illegal_nxt  = r_illegal;
        if (!BUSYWAIT) begin
            if (FLUSH) begin
                w_ex_nxt       = '0;
                w_ex_valid_nxt = 1'b0;
                w_illegal_nxt  = 1'b0;
                w_cnt_nxt      = '0;
                w_state_nxt    = S_ISSUE;
            end else if (r_state == S_MULTI) begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_ISSUE;
            end else begin
                w_ex_nxt       = '0;
                w_ex_valid_nxt = 1'b0;
                w_illegal_nxt  = 1'b0;
                if (IF_VALID) begin
                    if (w_dec_illegal) begin
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_ex_nxt       = w_dec_ctrl;
                        w_ex_valid_nxt = 1'b1;
                        if (w_dec_is_mul && MUL_MULTI) begin
                            w_cnt_nxt   = MUL_LOAD;
                            w_state_nxt = S_MULTI;
                        end else if (w_dec_is_div && DIV_MULTI) begin
                            w_cnt_nxt   = DIV_LOAD;
                            w_state_nxt = S_MULTI;
                        end
                    end
                end
            end
        end
    end

    // FSM state and occupancy counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_ISSUE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ex       <= '0;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_ex       <= w_ex_nxt;
            r_ex_valid <= w_ex_valid_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    // Stall drops in the same cycle the FSM leaves MULTI so the next word loads on that edge
    assign STALL        = BUSYWAIT | (r_state == S_MULTI);
    assign EX_VALID     = r_ex_valid;
    assign EX_RD        = r_ex.rd;
    assign ALUOP        = r_ex.aluop;
    assign IMMflag      = r_ex.immflag;
    assign SELECTWRITE  = r_ex.selectwrite;
    assign READ         = r_ex.read;
    assign WRITE        = r_ex.write;
    assign WRITEENABLE  = r_ex.writeenable;
    assign LOADSIGNAL   = r_ex.loadsignal;
    assign STORESIGNAL  = r_ex.storesignal;
    assign BRANCHSIGNAL = r_ex.branchsignal;
    assign JUMPSIGNAL   = r_ex.jumpsignal;
    assign ILLEGAL      = r_illegal;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// Bench for rv32im_decode_stage: decode table, MUL/DIV hold, busywait, flush and reset sequences.
module tb_rv32im_decode_stage;

    typedef struct packed {
        logic       stall;
        logic       ev;
        logic       ill;
        logic [4:0] rd;
        logic [4:0] aluop;
        logic       imm;
        logic       sel;
        logic       rd_en;
        logic       wr_en;
        logic       we;
        logic [2:0] ld;
        logic [1:0] st;
        logic [2:0] br;
        logic [1:0] jmp;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        out_t        exp;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        if_valid;
    logic        busywait;
    logic        flush;

    logic        stall, ex_valid, immflag, selectwrite, read, write, writeenable, illegal;
    logic [4:0]  ex_rd, aluop;
    logic [2:0]  loadsignal, branchsignal;
    logic [1:0]  storesignal, jumpsignal;

    logic        n_stall, n_ex_valid, n_immflag, n_selectwrite, n_read, n_write, n_writeenable, n_illegal;
    logic [4:0]  n_ex_rd, n_aluop;
    logic [2:0]  n_loadsignal, n_branchsignal;
    logic [1:0]  n_storesignal, n_jumpsignal;

    int checks;
    int failures;
    sb_t  sb[$];
    vec_t vecs[$];

    rv32im_decode_stage #(
        .ENABLE_M   (1'b1),
        .MUL_CYCLES (2),
        .DIV_CYCLES (8)
    ) u_dut (
        .CLK          (clk),
        .RESET        (rst),
        .INSTRUCTION  (instr),
        .IF_VALID     (if_valid),
        .BUSYWAIT     (busywait),
        .FLUSH        (flush),
        .STALL        (stall),
        .EX_VALID     (ex_valid),
        .EX_RD        (ex_rd),
        .ALUOP        (aluop),
        .IMMflag      (immflag),
        .SELECTWRITE  (selectwrite),
        .READ         (read),
        .WRITE        (write),
        .WRITEENABLE  (writeenable),
        .LOADSIGNAL   (loadsignal),
        .STORESIGNAL  (storesignal),
        .BRANCHSIGNAL (branchsignal),
        .JUMPSIGNAL   (jumpsignal),
        .ILLEGAL      (illegal)
    );

    rv32im_decode_stage #(
        .ENABLE_M   (1'b0),
        .MUL_CYCLES (2),
        .DIV_CYCLES (8)
    ) u_dut_nom (
        .CLK          (clk),
        .RESET        (rst),
        .INSTRUCTION  (instr),
        .IF_VALID     (if_valid),
        .BUSYWAIT     (busywait),
        .FLUSH        (flush),
        .STALL        (n_stall),
        .EX_VALID     (n_ex_valid),
        .EX_RD        (n_ex_rd),
        .ALUOP        (n_aluop),
        .IMMflag      (n_immflag),
        .SELECTWRITE  (n_selectwrite),
        .READ         (n_read),
        .WRITE        (n_write),
        .WRITEENABLE  (n_writeenable),
        .LOADSIGNAL   (n_loadsignal),
        .STORESIGNAL  (n_storesignal),
        .BRANCHSIGNAL (n_branchsignal),
        .JUMPSIGNAL   (n_jumpsignal),
        .ILLEGAL      (n_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected valid instruction (EX_VALID=1, ILLEGAL=0)
    function automatic out_t mk(input int unsigned alu, input int unsigned imm, input int unsigned sel,
                                input int unsigned rd_en, input int unsigned wr_en, input int unsigned we,
                                input int unsigned ld, input int unsigned st, input int unsigned br,
                                input int unsigned jmp, input int unsigned rd, input int unsigned stl);
        out_t o;
        o.stall = 1'(stl);
        o.ev    = 1'b1;
        o.ill   = 1'b0;
        o.rd    = 5'(rd);
        o.aluop = 5'(alu);
        o.imm   = 1'(imm);
        o.sel   = 1'(sel);
        o.rd_en = 1'(rd_en);
        o.wr_en = 1'(wr_en);
        o.we    = 1'(we);
        o.ld    = 3'(ld);
        o.st    = 2'(st);
        o.br    = 3'(br);
        o.jmp   = 2'(jmp);
        return o;
    endfunction

    function automatic out_t sample();
        out_t s;
        s.stall = stall;
        s.ev    = ex_valid;
        s.ill   = illegal;
        s.rd    = ex_rd;
        s.aluop = aluop;
        s.imm   = immflag;
        s.sel   = selectwrite;
        s.rd_en = read;
        s.wr_en = write;
        s.we    = writeenable;
        s.ld    = loadsignal;
        s.st    = storesignal;
        s.br    = branchsignal;
        s.jmp   = jumpsignal;
        return s;
    endfunction

    task automatic compare_head();
        sb_t  e;
        out_t a;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sb.pop_front();
            a = sample();
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h (stall=%b ev=%b ill=%b alu=%b) expected %h (stall=%b ev=%b ill=%b alu=%b)",
                         e.name, a, a.stall, a.ev, a.ill, a.aluop, e.exp, e.exp.stall, e.exp.ev, e.exp.ill, e.exp.aluop);
            end
        end
    endtask

    // Queue the expectation, let one edge pass, compare away from the edge
    task automatic step(input string name, input out_t exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic check_now(input string name, input out_t exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
        compare_head();
    endtask

    task automatic drive(input logic [31:0] w, input logic v);
        instr    = w;
        if_valid = v;
    endtask

    function automatic vec_t v(input string name, input logic [31:0] w, input logic val, input out_t exp);
        vec_t r;
        r.name  = name;
        r.instr = w;
        r.valid = val;
        r.exp   = exp;
        return r;
    endfunction

    out_t o_bub, o_ill, o_div, o_div_s, o_mul, o_mul_s, o_addi, o_lw, o_lw_s, o_sw;
    logic [7:0] nom_got;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        instr    = 32'h0;
        if_valid = 1'b0;
        busywait = 1'b0;
        flush    = 1'b0;

        o_bub     = '0;
        o_ill     = '0;
        o_ill.ill = 1'b1;
        o_addi    = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        o_div     = mk(13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0);
        o_div_s   = mk(13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
        o_mul     = mk(9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0);
        o_mul_s   = mk(9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
        o_lw      = mk(1, 1, 1, 1, 0, 1, 3, 0, 0, 0, 5, 0);
        o_lw_s    = mk(1, 1, 1, 1, 0, 1, 3, 0, 0, 0, 5, 1);
        o_sw      = mk(1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0);

        vecs.push_back(v("addi_x1",   32'h00500093, 1'b1, o_addi));
        vecs.push_back(v("add_x0",    32'h00208033, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(v("add_x3",    32'h002081B3, 1'b1, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0)));
        vecs.push_back(v("sub_x4",    32'h40208233, 1'b1, mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 0)));
        vecs.push_back(v("sra_x5",    32'h4020D2B3, 1'b1, mk(7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 0)));
        vecs.push_back(v("sltu_x6",   32'h0020B333, 1'b1, mk(18, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6, 0)));
        vecs.push_back(v("lw_x5",     32'h0000A283, 1'b1, o_lw));
        vecs.push_back(v("lbu_x7",    32'h0040C383, 1'b1, mk(1, 1, 1, 1, 0, 1, 4, 0, 0, 0, 7, 0)));
        vecs.push_back(v("sw",        32'h0050A023, 1'b1, o_sw));
        vecs.push_back(v("sb",        32'h005080A3, 1'b1, mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(v("bne",       32'h00209463, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0)));
        vecs.push_back(v("bgeu",      32'h0020F463, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0)));
        vecs.push_back(v("lui_x8",    32'h12345437, 1'b1, mk(0, 1, 0, 0, 0, 1, 6, 0, 0, 0, 8, 0)));
        vecs.push_back(v("auipc_x9",  32'h00001497, 1'b1, mk(1, 1, 0, 0, 0, 1, 6, 0, 0, 0, 9, 0)));
        vecs.push_back(v("jal_x1",    32'h010000EF, 1'b1, mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(v("jalr_x0",   32'h00008067, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0)));
        vecs.push_back(v("srai_x10",  32'h4030D513, 1'b1, mk(7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 10, 0)));
        vecs.push_back(v("all_ones",  32'hFFFFFFFF, 1'b1, o_ill));
        vecs.push_back(v("bubble",    32'h00500093, 1'b0, o_bub));
        vecs.push_back(v("bad_func7", 32'h60208233, 1'b1, o_ill));
        vecs.push_back(v("after_ill", 32'h00500093, 1'b1, o_addi));

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_now("reset_state", o_bub);
        rst = 1'b0;

        // Single-cycle decode table
        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].valid);
            step(vecs[i].name, vecs[i].exp);
        end

        // MUL with two-cycle occupancy: one stall cycle
        drive(32'h022081B3, 1'b1);
        step("mul_load", o_mul_s);
        drive(32'h00500093, 1'b1);
        step("mul_last", o_mul);
        step("mul_next", o_addi);

        // DIV: held with stall for 7 cycles, next word on the 8th edge
        drive(32'h0220C1B3, 1'b1);
        step("div_load", o_div_s);
        nom_got = {n_ex_valid, n_illegal, n_writeenable, n_aluop};
        checks++;
        if (nom_got !== 8'b0100_0000) begin
            failures++;
            $display("FAIL div_no_m: got ev/ill/we/alu=%b expected %b", nom_got, 8'b0100_0000);
        end
        drive(32'h00500093, 1'b1);
        for (int k = 1; k <= 6; k++) step("div_hold", o_div_s);
        step("div_last", o_div);
        step("div_next", o_addi);

        // LW held through three busy cycles, then SW
        drive(32'h0000A283, 1'b1);
        step("lw_load", o_lw);
        busywait = 1'b1;
        drive(32'h0050A023, 1'b1);
        #1;
        check_now("lw_busy_stall", o_lw_s);
        for (int k = 0; k < 3; k++) step("lw_busy_hold", o_lw_s);
        busywait = 1'b0;
        #1;
        check_now("lw_busy_release", o_lw);
        step("sw_after_busy", o_sw);

        // FLUSH while MULTI with counter at 4; FLUSH under BUSYWAIT holds
        drive(32'h0220C1B3, 1'b1);
        step("fl_div_load", o_div_s);
        drive(32'h00500093, 1'b1);
        for (int k = 0; k < 3; k++) step("fl_div_hold", o_div_s);
        flush    = 1'b1;
        busywait = 1'b1;
        step("flush_busy_hold", o_div_s);
        busywait = 1'b0;
        step("flush_bubble", o_bub);
        flush = 1'b0;
        step("flush_then_issue", o_addi);

        // Asynchronous reset in MULTI
        drive(32'h0220C1B3, 1'b1);
        step("rst_div_load", o_div_s);
        drive(32'h00500093, 1'b1);
        step("rst_div_hold", o_div_s);
        #3;
        rst = 1'b1;
        #1;
        check_now("async_reset", o_bub);
        #1;
        rst = 1'b0;
        step("reset_then_issue", o_addi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
